// File: rtl/demux9_pkg.sv
// Shared constants and types for the nine-slot write-side register bank.
package demux9_pkg;
    localparam int NUM_SLOTS = 9;
    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] LAST_SLOT = 4'd8;
    localparam logic [NUM_SLOTS-1:0] ALL_WRITTEN = 9'h1FF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/demux9_decode.sv
// 4-bit slot index to 9-bit one-hot enable; indices above 8 give no enable and
// raise the out-of-range flag.
module demux9_decode
    import demux9_pkg::*;
(
    input  logic [SEL_W-1:0]     i_idx,
    output logic [NUM_SLOTS-1:0] o_onehot,
    output logic                 o_out_of_range
);
    always_comb begin
        o_onehot       = '0;
        o_out_of_range = (i_idx > LAST_SLOT);
        if (!o_out_of_range)
            o_onehot[i_idx] = 1'b1;
    end
endmodule

// File: rtl/demux9_reg_bank.sv
// Distributes one write stream into nine registered slots with manual or
// round-robin addressing and a one-slot-per-cycle bank clear.
module demux9_reg_bank #(
    parameter int WIDTH     = 1,
    parameter int NUM_SLOTS = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           sel,
    input  logic                 auto_mode,
    input  logic                 clr,
    output logic [WIDTH-1:0]     out0,
    output logic [WIDTH-1:0]     out1,
    output logic [WIDTH-1:0]     out2,
    output logic [WIDTH-1:0]     out3,
    output logic [WIDTH-1:0]     out4,
    output logic [WIDTH-1:0]     out5,
    output logic [WIDTH-1:0]     out6,
    output logic [WIDTH-1:0]     out7,
    output logic [WIDTH-1:0]     out8,
    output logic [NUM_SLOTS-1:0] written,
    output logic                 full,
    output logic                 sel_err,
    output logic                 clr_done
);
    import demux9_pkg::*;

    state_t                r_state;
    logic [SEL_W-1:0]      r_rr_ptr;
    logic [SEL_W-1:0]      r_clr_ptr;
    logic [WIDTH-1:0]      r_slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  r_written;
    logic                  r_full;
    logic                  r_sel_err;
    logic                  r_clr_done;

    logic                  w_accept;
    logic [SEL_W-1:0]      w_target;
    logic [NUM_SLOTS-1:0]  w_wr_hot;
    logic                  w_wr_oor;
    logic [NUM_SLOTS-1:0]  w_clr_hot;
    logic                  w_clr_oor;
    logic [NUM_SLOTS-1:0]  w_wr_en;
    logic [NUM_SLOTS-1:0]  w_clr_en;
    logic [NUM_SLOTS-1:0]  w_written_nxt;

    assign in_ready = (r_state == IDLE) && !clr;
    assign w_accept = in_valid && in_ready;
    assign w_target = auto_mode ? r_rr_ptr : sel;

    demux9_decode u_wr_decode (
        .i_idx          (w_target),
        .o_onehot       (w_wr_hot),
        .o_out_of_range (w_wr_oor)
    );

    demux9_decode u_clr_decode (
        .i_idx          (r_clr_ptr),
        .o_onehot       (w_clr_hot),
        .o_out_of_range (w_clr_oor)
    );

    assign w_wr_en  = w_accept ? w_wr_hot : '0;
    assign w_clr_en = (r_state == CLEAR) ? w_clr_hot : '0;

    always_comb begin
        w_written_nxt = (r_written | w_wr_en) & ~w_clr_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_clr_ptr  <= '0;
            r_sel_err  <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_sel_err  <= w_accept && !auto_mode && w_wr_oor;
            r_clr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state   <= CLEAR;
                        r_clr_ptr <= '0;
                    end else if (w_accept && auto_mode) begin
                        r_rr_ptr <= (r_rr_ptr == LAST_SLOT) ? '0 : r_rr_ptr + 4'd1;
                    end
                end
                CLEAR: begin
                    // clr_ptr never leaves 0..8 while clearing, so w_clr_oor stays low here
                    if (r_clr_ptr == LAST_SLOT || w_clr_oor) begin
                        r_state    <= IDLE;
                        r_clr_ptr  <= '0;
                        r_rr_ptr   <= '0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_SLOTS; n++)
                r_slot[n] <= '0;
            r_written <= '0;
            r_full    <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_SLOTS; n++) begin
                if (w_wr_en[n])
                    r_slot[n] <= in_data;
                else if (w_clr_en[n])
                    r_slot[n] <= '0;
            end
            r_written <= w_written_nxt;
            r_full    <= (w_written_nxt == ALL_WRITTEN);
        end
    end

    assign out0     = r_slot[0];
    assign out1     = r_slot[1];
    assign out2     = r_slot[2];
    assign out3     = r_slot[3];
    assign out4     = r_slot[4];
    assign out5     = r_slot[5];
    assign out6     = r_slot[6];
    assign out7     = r_slot[7];
    assign out8     = r_slot[8];
    assign written  = r_written;
    assign full     = r_full;
    assign sel_err  = r_sel_err;
    assign clr_done = r_clr_done;
endmodule

// File: tb/tb_demux9_reg_bank.sv
// Directed plus randomized bench for demux9_reg_bank (WIDTH=8) against a
// slot-array reference model.
module tb_demux9_reg_bank;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sel;
    logic       auto_mode;
    logic       clr;
    logic [7:0] dout [9];
    logic [8:0] written;
    logic       full;
    logic       sel_err;
    logic       clr_done;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    logic [7:0] m_slot [9];
    logic       m_wr [9];
    int         m_rr;
    int         m_clear_left;
    logic       m_sel_err;
    logic       m_done;

    always #5 clk = ~clk;

    demux9_reg_bank #(.WIDTH(8), .NUM_SLOTS(9)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .auto_mode(auto_mode), .clr(clr),
        .out0(dout[0]), .out1(dout[1]), .out2(dout[2]), .out3(dout[3]),
        .out4(dout[4]), .out5(dout[5]), .out6(dout[6]), .out7(dout[7]),
        .out8(dout[8]), .written(written), .full(full), .sel_err(sel_err),
        .clr_done(clr_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] m_written_vec();
        logic [8:0] v;
        for (int i = 0; i < 9; i++) v[i] = m_wr[i];
        return v;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        int t;
        m_sel_err = 1'b0;
        m_done    = 1'b0;
        if (reset) begin
            for (int i = 0; i < 9; i++) begin m_slot[i] = 8'h00; m_wr[i] = 1'b0; end
            m_rr = 0;
            m_clear_left = 0;
        end else if (m_clear_left > 0) begin
            t = 9 - m_clear_left;
            m_slot[t] = 8'h00;
            m_wr[t]   = 1'b0;
            m_clear_left--;
            if (m_clear_left == 0) begin
                m_done = 1'b1;
                m_rr   = 0;
            end
        end else if (clr) begin
            m_clear_left = 9;
        end else if (in_valid) begin
            t = auto_mode ? m_rr : int'(sel);
            if (t < 9) begin
                m_slot[t] = in_data;
                m_wr[t]   = 1'b1;
            end else begin
                m_sel_err = 1'b1;
            end
            if (auto_mode) m_rr = (m_rr + 1) % 9;
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic v, input logic a,
                       input logic [3:0] s, input logic [7:0] d);
        reset = r; clr = c; in_valid = v; auto_mode = a; sel = s; in_data = d;
        #1;
        if (!r) chk("in_ready", in_ready, (m_clear_left == 0) && !c);
        model_edge();
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) chk($sformatf("out%0d", i), dout[i], m_slot[i]);
        chk("written", written, m_written_vec());
        chk("full", full, m_written_vec() == 9'h1FF);
        chk("sel_err", sel_err, m_sel_err);
        chk("clr_done", clr_done, m_done);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin m_slot[i] = 8'hxx; m_wr[i] = 1'bx; end
        m_rr = 0; m_clear_left = 0;
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; auto_mode = 1'b0; sel = 4'd0; in_data = 8'h00;
        @(posedge clk); #1;

        // reset state
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 8'h00);

        // manual writes to slots 0 and 8
        cyc(0, 0, 1, 0, 4'd0, 8'hA5);
        chk("man_out0", dout[0], 8'hA5);
        cyc(0, 0, 1, 0, 4'd8, 8'h3C);
        chk("man_out8", dout[8], 8'h3C);
        chk("man_written", written, 9'h101);
        chk("man_full", full, 1'b0);

        // out-of-range manual selects
        cyc(0, 0, 1, 0, 4'd9, 8'hFF);
        chk("sel9_err", sel_err, 1'b1);
        cyc(0, 0, 1, 0, 4'd15, 8'hFF);
        chk("sel15_err", sel_err, 1'b1);
        cyc(0, 0, 0, 0, 4'd0, 8'h00);
        chk("sel_err_drop", sel_err, 1'b0);

        // auto mode, ten writes wrapping onto slot 0
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 1, 1, 4'd15, 8'(k));
            if (k == 9) chk("auto_full9", full, 1'b1);
        end
        chk("auto_out0_wrap", dout[0], 8'd10);
        chk("auto_out1", dout[1], 8'd2);
        chk("auto_out8", dout[8], 8'd9);
        // next auto write goes to slot 1 (pointer advanced past the wrap)
        cyc(0, 0, 1, 1, 4'd0, 8'h77);
        chk("auto_rr1", dout[1], 8'h77);

        // clear with a colliding write, stray writes during the clear
        cyc(0, 1, 1, 1, 4'd0, 8'hEE);
        for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0, 4'd3, 8'h55);
        chk("clr_written", written, 9'h000);
        cyc(0, 0, 1, 1, 4'd5, 8'h42);
        chk("post_clr_auto", dout[0], 8'h42);

        // reset on the 4th clear cycle
        for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0, 4'(k), 8'($urandom));
        cyc(0, 1, 0, 0, 4'd0, 8'h00);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 4'd0, 8'h00);
        cyc(1, 0, 0, 0, 4'd0, 8'h00);
        chk("rst_mid_clr_written", written, 9'h000);
        cyc(0, 0, 1, 0, 4'd2, 8'h99);
        chk("rst_then_sel2", dout[2], 8'h99);

        // clr re-asserted mid-clear is ignored
        cyc(0, 1, 0, 0, 4'd0, 8'h00);
        for (int k = 0; k < 9; k++) cyc(0, (k == 3 || k == 4), 0, 0, 4'd0, 8'h00);
        chk("reclr_done_at9", clr_done, 1'b1);
        cyc(0, 0, 0, 0, 4'd0, 8'h00);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic r, c;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 6);
            cyc(r, c, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/demux9_reg_bank.md
Name: demux9_reg_bank

Overview:
- Write-side counterpart of the team's 9-input selector: takes one data stream and distributes it into nine registered output slots.
- The slots feed the 9-input selector's in0..in8 and are read back through it.
- Supports manual addressing, round-robin auto-addressing, and a sequenced bank clear.
- Sits between the control FSM, which produces values, and the selector/display path.

Parameters:
WIDTH, 1, data width of each slot and of in_data
NUM_SLOTS, 9, number of output slots; fixed at 9, not to be overridden

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  value to write
in_valid  input  1  write request
in_ready  output  1  write accepted this cycle when in_valid && in_ready
sel  input  4  target slot in manual mode; valid range 0..8
auto_mode  input  1  1 = target taken from internal round-robin pointer, sel ignored
clr  input  1  one-cycle request to clear all slots
out0..out8  output  WIDTH each  registered slot contents
written  output  9  bit n set once slot n has been written since the last reset or clear
full  output  1  written == 9'h1FF
sel_err  output  1  one-cycle pulse: manual write rejected because sel > 8
clr_done  output  1  one-cycle pulse when the clear sequence completes

Behaviour:
- Reset: synchronous, active-high, on the clk edge.
  - All out0..out8 = 0, written = 0, full = 0, sel_err = 0, clr_done = 0.
  - rr_ptr = 0, clr_ptr = 0, state = IDLE.
  - Reset dominates every other input. Reset during CLEAR aborts the clear and returns to IDLE with everything zeroed.
- FSM states: IDLE, CLEAR.
- in_ready is combinational: (state == IDLE) && !clr.
- Accept: in_valid && in_ready. The target slot is rr_ptr when auto_mode = 1, else sel.
- Write latency: on an accepted write with target <= 8, slot[target] <= in_data and written[target] <= 1 at the same edge. The new value is visible on outN the cycle after acceptance.
- Manual mode, sel in 9..15: no slot changes, written unchanged. sel_err = 1 for exactly the cycle after acceptance. The request still counts as accepted (in_ready stays 1) so the producer never stalls.
- Auto mode: rr_ptr increments on every accepted write and wraps 8 -> 0. Slots are overwritten freely on wrap. full stays 1 until a clear. sel_err never asserts in auto mode.
- Manual writes do not move rr_ptr.
- IDLE with clr = 1: enter CLEAR next edge, clr_ptr = 0. A simultaneous in_valid is not accepted (in_ready = 0).
- CLEAR:
  - Each cycle, slot[clr_ptr] <= 0, written[clr_ptr] <= 0, clr_ptr++.
  - After clearing slot 8: return to IDLE, rr_ptr <= 0, clr_done = 1 for one cycle (the first IDLE cycle).
  - Total: 9 cycles in CLEAR; in_ready = 0 throughout.
  - clr asserted during CLEAR is ignored; the sequence does not restart.
- full and written are registered and update at the same edge as the slot they describe.
- Outputs not targeted hold their value. No slot changes without an accepted write, a clear step or reset.

Decomposition:
- Shared package `demux9_pkg`:
  - NUM_SLOTS = 9, SEL_W = 4, LAST_SLOT = 4'd8
  - state typedef {IDLE, CLEAR}
  - ALL_WRITTEN = 9'h1FF
- Natural sub-module `demux9_decode`: combinational 4-bit index -> 9-bit one-hot enable, plus an out_of_range flag. Used for both the write target and clr_ptr.
- Slot registers, FSM and pointers stay in the top block.

Test Plan:
- Reset, then manual writes WIDTH=8: sel=0 data 8'hA5, sel=8 data 8'h3C -> out0=A5 and out8=3C one cycle after each accept; written=9'h101; full=0; other outs 0.
- Manual sel=9 data 8'hFF, then sel=15 -> no out changes, written unchanged, sel_err pulses exactly one cycle after each accept, in_ready stays 1.
- auto_mode=1, 10 consecutive writes data 1..10 -> out0..out8 = 10,2,3,...,9 (slot 0 overwritten on wrap), full=1 after the 9th accept, rr_ptr=1 at end.
- clr with in_valid=1 in the same cycle -> in_ready=0, write dropped; 9 CLEAR cycles zero slots 0..8 in order; written=0; clr_done pulses once; rr_ptr=0; the next auto write lands in out0.
- Reset asserted on the 4th CLEAR cycle -> next cycle state IDLE, all outs 0, written=0, no clr_done pulse; a following write to sel=2 succeeds.
- clr re-asserted mid-CLEAR -> ignored; clr_done arrives exactly 9 cycles after the original clr entry.
